fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a program ROM from RESET_PC and
// hands each word to an execute unit over a valid/ready handshake. The
// execute unit can redirect or halt the sequence on the accept cycle.
// The sequencer stops on a halt opcode or an out-of-range address.
module fetch_sequencer #(
  parameter int          ROM_DEPTH   = 16,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_opcode,
  input  logic [15:0] rom_operand,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_opcode,
  output logic [15:0] instr_operand,
  output logic [15:0] instr_pc,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  input  logic        halt_req,
  output logic        running,
  output logic        halted,
  output logic        addr_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // The depth is widened by one bit so a depth of 65536 still compares correctly.
  localparam logic [16:0] DEPTH_W = 17'(ROM_DEPTH);

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] opcode_reg, opcode_next;
  logic [15:0] operand_reg, operand_next;
  logic [15:0] ipc_reg, ipc_next;
  logic        fault_reg, fault_next;

  logic accept;
  logic pc_out_of_range;

  assign accept          = (state_reg == ISSUE) && instr_ready;
  assign pc_out_of_range = ({1'b0, pc_reg} >= DEPTH_W);

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      opcode_reg  <= 16'h0000;
      operand_reg <= 16'h0000;
      ipc_reg     <= 16'h0000;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      ipc_reg     <= ipc_next;
      fault_reg   <= fault_next;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    ipc_next     = ipc_reg;
    fault_next   = fault_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        // The range check wins: data read beyond the program is meaningless.
        if (pc_out_of_range) begin
          state_next = HALTED;
          fault_next = 1'b1;
        end else if (rom_opcode == HALT_OPCODE) begin
          state_next = HALTED;
        end else begin
          opcode_next  = rom_opcode;
          operand_next = rom_operand;
          ipc_next     = pc_reg;
          pc_next      = pc_reg + 16'd1;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        // Branch and halt requests only count when the instruction is taken.
        if (accept) begin
          if (halt_req) begin
            state_next = HALTED;
          end else if (branch_valid) begin
            pc_next    = branch_target;
            state_next = FETCH;
          end else begin
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        if (start) begin
          pc_next    = RESET_PC;
          fault_next = 1'b0;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rom_addr      = pc_reg;
  assign instr_valid   = (state_reg == ISSUE);
  assign instr_opcode  = opcode_reg;
  assign instr_operand = operand_reg;
  assign instr_pc      = ipc_reg;
  assign running       = (state_reg == FETCH) || (state_reg == ISSUE);
  assign halted        = (state_reg == HALTED);
  assign addr_fault    = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a 16-word ROM model drives the sequencer.
// Directed scenarios run first, then randomized programs. A program-level
// reference decides what each fetch must produce.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] rom_addr;
  logic [15:0] rom_opcode;
  logic [15:0] rom_operand;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_opcode;
  logic [15:0] instr_operand;
  logic [15:0] instr_pc;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        halt_req;
  logic        running;
  logic        halted;
  logic        addr_fault;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rom_addr      (rom_addr),
    .rom_opcode    (rom_opcode),
    .rom_operand   (rom_operand),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_pc      (instr_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .running       (running),
    .halted        (halted),
    .addr_fault    (addr_fault)
  );

  // Program ROM: words beyond the program read as zero.
  logic [31:0] rom [0:15];
  assign rom_opcode  = (rom_addr < 16'd16) ? rom[rom_addr[3:0]][31:16] : 16'h0000;
  assign rom_operand = (rom_addr < 16'd16) ? rom[rom_addr[3:0]][15:0]  : 16'h0000;

  int total  = 0;
  int passed = 0;

  // Reference: address of the next fetch and the instruction currently held.
  logic [15:0] mpc;
  logic [15:0] cur_op   = 16'h0000;
  logic [15:0] cur_opnd = 16'h0000;
  logic [15:0] cur_pc   = 16'h0000;
  int          issues;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic fill_rom(input int halt_one_in);
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if (halt_one_in > 0 && $urandom_range(0, halt_one_in - 1) == 0) w[31:16] = 16'hFFFF;
      else if (w[31:16] == 16'hFFFF) w[31:16] = 16'h1234;
      rom[i] = w;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    mpc = 16'h0000;
    check("start_running", {31'd0, running}, 32'd1);
    check("start_fault_clr", {31'd0, addr_fault}, 32'd0);
    check("start_no_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  // Called while the sequencer is fetching; one edge later it must have
  // issued the word at mpc, halted on a halt opcode, or faulted.
  task automatic fetch_step(output bit issued);
    logic [31:0] w;
    bit exp_fault;
    exp_fault = (mpc >= 16'd16);
    w = exp_fault ? 32'h0 : rom[mpc[3:0]];
    issued = 1'b0;
    check("fetch_addr", {16'd0, rom_addr}, {16'd0, mpc});
    tick();
    if (exp_fault) begin
      $display("fault at pc=%h", mpc);
      check("fault_halted", {31'd0, halted}, 32'd1);
      check("fault_flag", {31'd0, addr_fault}, 32'd1);
      check("fault_no_valid", {31'd0, instr_valid}, 32'd0);
      check("fault_ir_kept", {16'd0, instr_opcode}, {16'd0, cur_op});
    end else if (w[31:16] == 16'hFFFF) begin
      $display("halt opcode at pc=%h", mpc);
      check("hop_halted", {31'd0, halted}, 32'd1);
      check("hop_no_fault", {31'd0, addr_fault}, 32'd0);
      check("hop_pc_kept", {16'd0, rom_addr}, {16'd0, mpc});
      check("hop_no_valid", {31'd0, instr_valid}, 32'd0);
    end else begin
      cur_op   = w[31:16];
      cur_opnd = w[15:0];
      cur_pc   = mpc;
      mpc      = mpc + 16'd1;
      issued   = 1'b1;
      issues++;
      $display("issue pc=%h op=%h operand=%h", cur_pc, cur_op, cur_opnd);
      check("iss_valid", {31'd0, instr_valid}, 32'd1);
      check("iss_opcode", {16'd0, instr_opcode}, {16'd0, cur_op});
      check("iss_operand", {16'd0, instr_operand}, {16'd0, cur_opnd});
      check("iss_pc", {16'd0, instr_pc}, {16'd0, cur_pc});
      check("iss_next_pc", {16'd0, rom_addr}, {16'd0, mpc});
    end
  endtask

  // Stall for a number of cycles with noisy side inputs, then accept.
  task automatic issue_phase(input int stall, input bit br, input logic [15:0] tgt,
                             input bit hr, output bit stopped);
    stopped = 1'b0;
    for (int s = 0; s < stall; s++) begin
      instr_ready   = 1'b0;
      branch_valid  = 1'($urandom);
      halt_req      = 1'($urandom);
      branch_target = 16'($urandom);
      start         = 1'($urandom);
      tick();
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_opcode", {16'd0, instr_opcode}, {16'd0, cur_op});
      check("stall_operand", {16'd0, instr_operand}, {16'd0, cur_opnd});
      check("stall_pc", {16'd0, instr_pc}, {16'd0, cur_pc});
      check("stall_rom_addr", {16'd0, rom_addr}, {16'd0, mpc});
    end
    start         = 1'b0;
    instr_ready   = 1'b1;
    branch_valid  = br;
    halt_req      = hr;
    branch_target = tgt;
    tick();
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    halt_req     = 1'b0;
    check("acc_valid_drop", {31'd0, instr_valid}, 32'd0);
    if (hr) begin
      $display("accept pc=%h with halt", cur_pc);
      stopped = 1'b1;
      check("acc_halted", {31'd0, halted}, 32'd1);
      check("acc_halt_pc", {16'd0, rom_addr}, {16'd0, mpc});
    end else begin
      if (br) mpc = tgt;
      $display("accept pc=%h next=%h", cur_pc, mpc);
      check("acc_running", {31'd0, running}, 32'd1);
      check("acc_next_pc", {16'd0, rom_addr}, {16'd0, mpc});
    end
  endtask

  initial begin
    bit issued;
    bit stopped;
    bit br;
    bit hr;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 16'h0000; halt_req = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_opcode", {16'd0, instr_opcode}, 32'd0);
    check("rst_pc_out", {16'd0, rom_addr}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, addr_fault}, 32'd0);
    tick();
    check("idle_stays", {31'd0, running}, 32'd0);

    // Short program ending in a halt opcode.
    fill_rom(0);
    rom[0] = 32'h0001_0005;
    rom[1] = 32'h0002_0007;
    rom[2] = 32'hFFFF_0000;
    start_pulse();
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      fetch_step(issued);
      if (!issued) break;
      issue_phase(0, 1'b0, 16'h0, 1'b0, stopped);
    end
    check("prog_issues", issues, 2);
    check("prog_halted", {31'd0, halted}, 32'd1);

    // Long stall, branch back to 0, then branch+halt together.
    fill_rom(0);
    start_pulse();
    fetch_step(issued);
    issue_phase(5, 1'b0, 16'h0, 1'b0, stopped);
    fetch_step(issued);
    issue_phase(0, 1'b1, 16'h0000, 1'b0, stopped);
    fetch_step(issued);
    check("branch_pc0", {16'd0, instr_pc}, 32'd0);
    issue_phase(2, 1'b1, 16'h0009, 1'b1, stopped);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_no_issue", {31'd0, instr_valid}, 32'd0);
      check("halt_pc_kept", {16'd0, rom_addr}, {16'd0, mpc});
    end

    // Run off the end of the ROM, then restart.
    fill_rom(0);
    start_pulse();
    issues = 0;
    for (int k = 0; k < 20; k++) begin
      fetch_step(issued);
      if (!issued) break;
      issue_phase(0, 1'b0, 16'h0, 1'b0, stopped);
    end
    check("end_issues", issues, 16);
    check("end_fault", {31'd0, addr_fault}, 32'd1);
    start_pulse();
    check("restart_pc", {16'd0, rom_addr}, 32'd0);
    fetch_step(issued);
    issue_phase(1, 1'b0, 16'h0, 1'b1, stopped);

    // Randomized programs with branches, stalls and halts.
    for (int r = 0; r < 12; r++) begin
      fill_rom(8);
      start_pulse();
      for (int k = 0; k < 40; k++) begin
        fetch_step(issued);
        if (!issued) break;
        br = ($urandom_range(0, 3) == 0);
        hr = ($urandom_range(0, 15) == 0) || (k == 39);
        issue_phase($urandom_range(0, 3), br, 16'($urandom_range(0, 19)), hr, stopped);
        if (stopped) break;
      end
      check("rand_halted", {31'd0, halted}, 32'd1);
    end

    // Reset while an instruction is stalled.
    fill_rom(0);
    start_pulse();
    fetch_step(issued);
    issue_phase(0, 1'b0, 16'h0, 1'b0, stopped);
    fetch_step(issued);
    instr_ready = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1; instr_ready = 1'b1; branch_valid = 1'b1; halt_req = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0; halt_req = 1'b0;
    cur_op = 16'h0; cur_opnd = 16'h0; cur_pc = 16'h0; mpc = 16'h0;
    check("rrst_valid", {31'd0, instr_valid}, 32'd0);
    check("rrst_opcode", {16'd0, instr_opcode}, 32'd0);
    check("rrst_operand", {16'd0, instr_operand}, 32'd0);
    check("rrst_ipc", {16'd0, instr_pc}, 32'd0);
    check("rrst_pc", {16'd0, rom_addr}, 32'd0);
    check("rrst_running", {31'd0, running}, 32'd0);
    check("rrst_halted", {31'd0, halted}, 32'd0);
    tick();
    check("rrst_idle", {31'd0, running}, 32'd0);
    start_pulse();
    fetch_step(issued);
    check("rrst_first_pc", {16'd0, instr_pc}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
